// File: rtl/vc_linefill_db_pkg.sv
// Shared types and defaults for the vector-cache linefill data buffer.
// Optional protocol checking is enabled with VC_LFDB_ERR_CHK_EN.
package vc_linefill_db_pkg;

  localparam int VC_LFDB_ENTRY_NUM  = 32;
  localparam int VC_LFDB_BEATS      = 8;
  localparam int VC_LFDB_BEAT_WIDTH = 128;
  localparam int VC_LFDB_ID_W       = $clog2(VC_LFDB_ENTRY_NUM);
  localparam int VC_LFDB_LINE_W     = VC_LFDB_BEAT_WIDTH * VC_LFDB_BEATS;

  typedef enum logic [1:0] {
    LFDB_FREE  = 2'd0,
    LFDB_ALLOC = 2'd1,
    LFDB_READY = 2'd2
  } lfdb_state_e;

  typedef struct packed {
    logic [VC_LFDB_ID_W-1:0]   id;
    logic [VC_LFDB_LINE_W-1:0] data;
  } lfdb_out_pld_t;

endpackage

// File: rtl/vc_lfdb_id_fifo.sv
// Completion-order queue of entry IDs for the linefill data buffer.
// DEPTH is a power of two so the pointers wrap naturally.
module vc_lfdb_id_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_id,
  input  logic         pop,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/vc_linefill_db.sv
// Linefill data buffer: allocates entries, gathers beats, emits lines in
// completion order. Define VC_LFDB_ERR_CHK_EN to enable the err checker.
module vc_linefill_db
  import vc_linefill_db_pkg::*;
#(
  parameter int ENTRY_NUM  = VC_LFDB_ENTRY_NUM,
  parameter int BEAT_WIDTH = VC_LFDB_BEAT_WIDTH,
  parameter int BEATS      = VC_LFDB_BEATS,
  localparam int LINE_WIDTH = BEAT_WIDTH * BEATS,
  localparam int ID_W       = $clog2(ENTRY_NUM),
  localparam int FC_W       = $clog2(ENTRY_NUM + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  alloc_vld,
  input  logic                  alloc_rdy,
  output logic [ID_W-1:0]       alloc_id,
  output logic [FC_W-1:0]       free_cnt,
  input  logic                  beat_vld,
  output logic                  beat_rdy,
  input  logic [ID_W-1:0]       beat_id,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  input  logic                  beat_last,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [ID_W-1:0]       out_id,
  output logic [LINE_WIDTH-1:0] out_data,
  output logic                  err
);

  localparam int CNT_W = $clog2(BEATS);

  lfdb_state_e           st  [ENTRY_NUM];
  logic [CNT_W-1:0]      cnt [ENTRY_NUM];
  logic [BEAT_WIDTH-1:0] mem [ENTRY_NUM][BEATS];
  logic [FC_W-1:0]       free_q;
  logic [ID_W-1:0]       head;
  logic [CNT_W-1:0]      beat_cnt;
  logic                  empty;
  logic                  alloc_fire;
  logic                  beat_ok;
  logic                  beat_end;
  logic                  beat_done;
  logic                  pop;

  // Descending scan leaves the lowest FREE index selected.
  always_comb begin
    alloc_vld = 1'b0;
    alloc_id  = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (st[i] == LFDB_FREE) begin
        alloc_vld = 1'b1;
        alloc_id  = ID_W'(i);
      end
    end
  end

  assign alloc_fire = alloc_vld && alloc_rdy;
  assign free_cnt   = free_q;
  assign beat_rdy   = 1'b1;
  assign beat_cnt   = cnt[beat_id];
  assign beat_ok    = beat_vld && (st[beat_id] == LFDB_ALLOC);
  assign beat_end   = (beat_cnt == CNT_W'(BEATS - 1));
  assign beat_done  = beat_ok && beat_end;
  assign out_vld    = !empty;
  assign pop        = out_vld && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        st[i]  <= LFDB_FREE;
        cnt[i] <= '0;
      end
      free_q <= FC_W'(ENTRY_NUM);
    end else begin
      free_q <= free_q + FC_W'(pop) - FC_W'(alloc_fire);
      if (alloc_fire) begin
        st[alloc_id]  <= LFDB_ALLOC;
        cnt[alloc_id] <= '0;
      end
      if (beat_ok) begin
        cnt[beat_id] <= beat_end ? '0 : beat_cnt + CNT_W'(1);
        if (beat_end) st[beat_id] <= LFDB_READY;
      end
      if (pop) st[head] <= LFDB_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok) mem[beat_id][beat_cnt] <= beat_data;
  end

  vc_lfdb_id_fifo #(
    .DEPTH (ENTRY_NUM),
    .W     (ID_W)
  ) u_rdy_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (beat_done),
    .push_id (beat_id),
    .pop     (pop),
    .empty   (empty),
    .head    (head)
  );

  assign out_id = out_vld ? head : '0;

  always_comb begin
    out_data = '0;
    if (out_vld) begin
      for (int k = 0; k < BEATS; k++) begin
        out_data[k*BEAT_WIDTH +: BEAT_WIDTH] = mem[head][k];
      end
    end
  end

`ifdef VC_LFDB_ERR_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= beat_vld &&
               ((st[beat_id] != LFDB_ALLOC) || (beat_last != beat_end));
    end
  end

  assign err = err_q;
`else
  logic unused_last;

  assign unused_last = beat_last;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_vc_linefill_db.sv
// Directed self-checking bench for vc_linefill_db (default parameters).
// Error expectations follow VC_LFDB_ERR_CHK_EN when it is defined.
module tb_vc_linefill_db;

  localparam int EN = 32;
  localparam int BW = 128;
  localparam int NB = 8;
  localparam int LW = BW * NB;
  localparam int IW = 5;
  localparam int FW = 6;
`ifdef VC_LFDB_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          alloc_vld;
  logic          alloc_rdy;
  logic [IW-1:0] alloc_id;
  logic [FW-1:0] free_cnt;
  logic          beat_vld;
  logic          beat_rdy;
  logic [IW-1:0] beat_id;
  logic [BW-1:0] beat_data;
  logic          beat_last;
  logic          out_vld;
  logic          out_rdy;
  logic [IW-1:0] out_id;
  logic [LW-1:0] out_data;
  logic          err;

  int checks = 0;
  int errors = 0;

  vc_linefill_db dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_vld (alloc_vld),
    .alloc_rdy (alloc_rdy),
    .alloc_id  (alloc_id),
    .free_cnt  (free_cnt),
    .beat_vld  (beat_vld),
    .beat_rdy  (beat_rdy),
    .beat_id   (beat_id),
    .beat_data (beat_data),
    .beat_last (beat_last),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_id    (out_id),
    .out_data  (out_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] pat(input int tag, input int k);
    pat = (BW'(tag) << 64) | BW'(k * 17);
  endfunction

  function automatic logic [LW-1:0] line(input int tag);
    line = '0;
    for (int k = 0; k < NB; k++) line[k*BW +: BW] = pat(tag, k);
  endfunction

  task automatic beat(input int id, input logic [BW-1:0] d, input bit last);
    beat_vld  = 1'b1;
    beat_id   = IW'(id);
    beat_data = d;
    beat_last = last;
    tick();
    beat_vld  = 1'b0;
    beat_last = 1'b0;
  endtask

  task automatic fill(input int id, input int tag);
    for (int k = 0; k < NB; k++) beat(id, pat(tag, k), k == NB - 1);
  endtask

  initial begin
    rst_n = 1'b0; alloc_rdy = 1'b0; beat_vld = 1'b0; beat_id = '0;
    beat_data = '0; beat_last = 1'b0; out_rdy = 1'b0;
    #12;
    chk("rst_alloc_vld", alloc_vld, 1);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_free_cnt", free_cnt, EN);
    chk("rst_beat_rdy", beat_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // full allocation
    alloc_rdy = 1'b1;
    for (int i = 0; i < EN; i++) begin
      chk("fa_vld", alloc_vld, 1);
      chk("fa_id", alloc_id, i);
      chk("fa_free", free_cnt, EN - i);
      tick();
    end
    alloc_rdy = 1'b0;
    chk("fa_vld_end", alloc_vld, 0);
    chk("fa_free_end", free_cnt, 0);

    // single line into entry 5
    for (int k = 0; k < NB - 1; k++) beat(5, pat(0, k), 1'b0);
    chk("sl_not_yet", out_vld, 0);
    beat(5, pat(0, NB - 1), 1'b1);
    chk("sl_vld", out_vld, 1);
    chk("sl_id", out_id, 5);
    chk("sl_data", out_data, line(0));
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("sl_pop_vld", out_vld, 0);
    chk("sl_pop_free", free_cnt, 1);
    chk("sl_pop_aid", alloc_id, 5);

    // beat to a FREE entry is dropped
    beat(5, '1, 1'b1);
    chk("drop_err", err, ERR_EN);
    chk("drop_free", free_cnt, 1);
    chk("drop_vld", out_vld, 0);
    chk("drop_aid", alloc_id, 5);
    tick();
    chk("drop_err_off", err, 0);
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    chk("realloc_free", free_cnt, 0);
    chk("realloc_vld", alloc_vld, 0);

    // interleaved entries 9 and 2, 9 completes first
    for (int k = 0; k < NB; k++) begin
      beat(9, pat(9, k), k == NB - 1);
      if (k < NB - 1) chk("il_not_yet", out_vld, 0);
      else chk("il_first_id", out_id, 9);
      beat(2, pat(2, k), k == NB - 1);
    end
    chk("il_hold_id", out_id, 9);
    chk("il_data9", out_data, line(9));
    out_rdy = 1'b1;
    tick();
    chk("il_id2", out_id, 2);
    chk("il_data2", out_data, line(2));
    tick();
    out_rdy = 1'b0;
    chk("il_empty", out_vld, 0);
    chk("il_free", free_cnt, 2);

    // backpressure, completion order 12, 10, 11
    fill(12, 12);
    fill(10, 10);
    fill(11, 11);
    for (int c = 0; c < 3; c++) begin
      chk("bp_vld", out_vld, 1);
      chk("bp_id", out_id, 12);
      chk("bp_data", out_data, line(12));
      tick();
    end
    out_rdy = 1'b1;
    alloc_rdy = 1'b1;
    chk("bp_aid", alloc_id, 2);
    chk("bp_free0", free_cnt, 2);
    tick();
    alloc_rdy = 1'b0;
    chk("bp_id10", out_id, 10);
    chk("bp_data10", out_data, line(10));
    chk("bp_free1", free_cnt, 2);
    chk("bp_aid1", alloc_id, 9);
    tick();
    chk("bp_id11", out_id, 11);
    chk("bp_data11", out_data, line(11));
    chk("bp_free2", free_cnt, 3);
    tick();
    out_rdy = 1'b0;
    chk("bp_empty", out_vld, 0);
    chk("bp_free3", free_cnt, 4);

    // error path: beat to FREE entry 9, then early beat_last on entry 2
    beat(9, pat(1, 1), 1'b0);
    chk("ef_err", err, ERR_EN);
    tick();
    chk("ef_err_off", err, 0);
    chk("ef_free", free_cnt, 4);
    chk("ef_aid", alloc_id, 9);
    for (int k = 0; k < NB; k++) begin
      beat(2, pat(7, k), (k == 3) || (k == NB - 1));
      chk("em_err", err, (k == 3) ? ERR_EN : 1'b0);
      if (k == NB - 2) chk("em_not_yet", out_vld, 0);
    end
    chk("em_vld", out_vld, 1);
    chk("em_id", out_id, 2);
    chk("em_data", out_data, line(7));
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("em_free", free_cnt, 5);

    // reset with one queued line and one partial line
    fill(1, 1);
    for (int k = 0; k < 4; k++) beat(0, pat(3, k), 1'b0);
    chk("mr_pre_vld", out_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_free", free_cnt, EN);
    chk("mr_async_vld", out_vld, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mr_free", free_cnt, EN);
    chk("mr_vld", out_vld, 0);
    chk("mr_aid", alloc_id, 0);
    chk("mr_err", err, 0);
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    chk("mr_aid_next", alloc_id, 1);
    chk("mr_free_next", free_cnt, EN - 1);
    for (int k = 0; k < NB - 1; k++) beat(0, pat(20, k), 1'b0);
    chk("mr_not_yet", out_vld, 0);
    beat(0, pat(20, NB - 1), 1'b1);
    chk("mr_line_vld", out_vld, 1);
    chk("mr_line_id", out_id, 0);
    chk("mr_line_data", out_data, line(20));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
